// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - ex_type access encodings (funct3 style)
//   - FSM state enum lsu_state_t
//   - lsu_size_log2: log2 of the access size in bytes for a given type
package lsu_pkg;

  localparam logic [2:0] LSU_B   = 3'b000;
  localparam logic [2:0] LSU_H   = 3'b001;
  localparam logic [2:0] LSU_W   = 3'b010;
  localparam logic [2:0] LSU_D   = 3'b011;
  localparam logic [2:0] LSU_BU  = 3'b100;
  localparam logic [2:0] LSU_HU  = 3'b101;
  localparam logic [2:0] LSU_WU  = 3'b110;
  localparam logic [2:0] LSU_BAD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  // Access size as log2(bytes): 0=byte, 1=half, 2=word, 3=double.
  function automatic logic [1:0] lsu_size_log2(input logic [2:0] typ);
    return typ[1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   typ       access type (ex_type encoding)
//   off       byte offset within the bus word, already rounded to the access size
//   wdata     LSB-aligned store data
//   rdata     raw bus read data
//   be        byte enables for the access
//   wdata_rep store data replicated across every lane of its size
//   rdata_ext load data shifted down and sign/zero extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]                 typ,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN/8-1:0]          be,
  output logic [XLEN-1:0]            wdata_rep,
  output logic [XLEN-1:0]            rdata_ext
);

  localparam int unsigned NB = XLEN / 8;

  logic [1:0]      sz;
  logic [XLEN-1:0] shifted;

  // Byte enables and store replication depend only on the access size.
  always_comb begin
    sz = lsu_size_log2(typ);
    case (sz)
      2'd0: begin
        be        = NB'(8'h01) << off;
        wdata_rep = {NB{wdata[7:0]}};
      end
      2'd1: begin
        be        = NB'(8'h03) << off;
        wdata_rep = {(NB/2){wdata[15:0]}};
      end
      2'd2: begin
        be        = NB'(8'h0F) << off;
        wdata_rep = {(NB/4){wdata[31:0]}};
      end
      default: begin
        be        = NB'(8'hFF);
        wdata_rep = wdata;
      end
    endcase
  end

  assign shifted = rdata >> {off, 3'b000};

  // Signed size casts sign-extend; unsigned ones zero-extend.
  always_comb begin
    case (typ)
      LSU_B:   rdata_ext = XLEN'($signed(shifted[7:0]));
      LSU_H:   rdata_ext = XLEN'($signed(shifted[15:0]));
      LSU_W:   rdata_ext = XLEN'($signed(shifted[31:0]));
      LSU_BU:  rdata_ext = XLEN'(shifted[7:0]);
      LSU_HU:  rdata_ext = XLEN'(shifted[15:0]);
      LSU_WU:  rdata_ext = XLEN'(shifted[31:0]);
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit with a req/ack bus handshake, lane steering,
// load extension, bus timeout and error reporting.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses raise err
// instead of being rounded down to the access size).
// Ports:
//   clk, rst (sync, active-low)
//   ex_*     operation from the EX/MEM register
//   stall    combinational pipeline hold
//   wb_*     registered completion to MEM/WB, err one-cycle error pulse
//   bus_*    registered request side of the memory bus, bus_ack/bus_rdata back
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic               ex_rd,
  input  logic               ex_wr,
  input  logic [2:0]         ex_type,
  input  logic [ADDR_W-1:0]  ex_addr,
  input  logic [XLEN-1:0]    ex_wdata,
  input  logic [4:0]         ex_rd_idx,
  output logic               stall,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [4:0]         wb_rd_idx,
  output logic [XLEN-1:0]    wb_data,
  output logic               err,
  output logic               bus_req,
  output logic               bus_we,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [XLEN/8-1:0]  bus_be,
  output logic [XLEN-1:0]    bus_wdata,
  input  logic               bus_ack,
  input  logic [XLEN-1:0]    bus_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  lsu_state_t        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [2:0]        op_type, op_type_d;
  logic [OFF_W-1:0]  op_off, op_off_d;
  logic [4:0]        op_rd_idx, op_rd_idx_d;
  logic              op_load, op_load_d;

  logic              bus_req_d, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [NB-1:0]     bus_be_d;
  logic [XLEN-1:0]   bus_wdata_d;
  logic              wb_valid_d, wb_we_d, err_d;
  logic [4:0]        wb_rd_idx_d;
  logic [XLEN-1:0]   wb_data_d;
  logic              stall_c;

  logic              mem_op, type_ok, legal;
  logic [1:0]        ex_sz;
  logic [OFF_W-1:0]  off_raw, mis_mask, off_eff;
  logic [2:0]        al_type;
  logic [OFF_W-1:0]  al_off;
  logic [NB-1:0]     al_be;
  logic [XLEN-1:0]   al_wdata, al_rdata;

  // Access decode: size mask of the low address bits that must be zero.
  always_comb begin
    ex_sz = lsu_size_log2(ex_type);
    case (ex_sz)
      2'd0:    mis_mask = '0;
      2'd1:    mis_mask = OFF_W'(3'd1);
      2'd2:    mis_mask = OFF_W'(3'd3);
      default: mis_mask = OFF_W'(3'd7);
    endcase
  end

  assign mem_op  = ex_valid & (ex_rd | ex_wr);
  assign off_raw = ex_addr[OFF_W-1:0];
  assign off_eff = off_raw & ~mis_mask;
  assign type_ok = (ex_type != LSU_BAD) &&
                   !((XLEN == 32) && ((ex_type == LSU_D) || (ex_type == LSU_WU)));

`ifdef LSU_MISALIGN_TRAP_EN
  assign legal = type_ok & ~(|(off_raw & mis_mask));
`else
  assign legal = type_ok;
`endif

  // One steering instance: request fields from EX in IDLE, load data from the latched op in REQ.
  assign al_type = (state == ST_IDLE) ? ex_type : op_type;
  assign al_off  = (state == ST_IDLE) ? off_eff : op_off;

  lsu_align #(.XLEN(XLEN)) u_align (
    .typ       (al_type),
    .off       (al_off),
    .wdata     (ex_wdata),
    .rdata     (bus_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    op_type_d   = op_type;
    op_off_d    = op_off;
    op_rd_idx_d = op_rd_idx;
    op_load_d   = op_load;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_be_d    = bus_be;
    bus_wdata_d = bus_wdata;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_idx_d = '0;
    wb_data_d   = '0;
    err_d       = 1'b0;
    stall_c     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          stall_c     = 1'b1;
          op_type_d   = ex_type;
          op_off_d    = off_eff;
          op_rd_idx_d = ex_rd_idx;
          op_load_d   = ex_rd;
          if (legal) begin
            state_d     = ST_REQ;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = ex_wr;
            bus_addr_d  = {ex_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            bus_be_d    = al_be;
            bus_wdata_d = al_wdata;
          end else begin
            // Illegal access completes immediately without touching the bus.
            state_d     = ST_RESP;
            wb_valid_d  = 1'b1;
            wb_rd_idx_d = ex_rd_idx;
            err_d       = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (bus_ack || ((TIMEOUT != 0) && (cnt == CNT_LAST))) begin
          state_d     = ST_RESP;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          wb_valid_d  = 1'b1;
          wb_rd_idx_d = op_rd_idx;
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus_ack) begin
            wb_we_d   = op_load;
            wb_data_d = op_load ? al_rdata : '0;
          end else begin
            err_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stall = rst & stall_c;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_type   <= '0;
      op_off    <= '0;
      op_rd_idx <= '0;
      op_load   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd_idx <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      op_type   <= op_type_d;
      op_off    <= op_off_d;
      op_rd_idx <= op_rd_idx_d;
      op_load   <= op_load_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_be    <= bus_be_d;
      bus_wdata <= bus_wdata_d;
      wb_valid  <= wb_valid_d;
      wb_we     <= wb_we_d;
      wb_rd_idx <= wb_rd_idx_d;
      wb_data   <= wb_data_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage (XLEN=32, TIMEOUT=4).
// Directed vector table, hand-written reset/idle sequences, and randomized
// operations checked against a byte-level reference model.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_rd, ex_wr;
  logic [2:0]  ex_type;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd_idx;
  logic        stall, wb_valid, wb_we, err;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_data;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_type(ex_type),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd_idx(ex_rd_idx),
    .stall(stall), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd_idx(wb_rd_idx),
    .wb_data(wb_data), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [2:0]  typ;
    logic        is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_err;
    logic        e_we;
    int          e_nreq;
    int          e_lat;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] typ, input logic is_load,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_dly,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_data,
                              input logic e_err, input logic e_we,
                              input int e_nreq, input int e_lat);
    vec_t v;
    v.typ = typ; v.is_load = is_load; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.ack_dly = ack_dly; v.e_addr = e_addr; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_data = e_data; v.e_err = e_err; v.e_we = e_we;
    v.e_nreq = e_nreq; v.e_lat = e_lat;
    return v;
  endfunction

  // Reference model: works on byte sizes and plain arithmetic.
  function automatic vec_t model(input logic [2:0] typ, input logic is_load,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ack_dly);
    vec_t v;
    int size, off;
    bit legal;
    longint unsigned mask, val;
    v = mk(typ, is_load, addr, wdata, rdata, ack_dly, 0, 0, 0, 0, 0, 0, 0, 0);
    size  = 1 << int'(typ[1:0]);
    off   = int'(addr % 4);
    legal = !(typ == 3'b111 || typ == 3'b011 || typ == 3'b110);
`ifdef LSU_MISALIGN_TRAP_EN
    if (off % size != 0) legal = 0;
`endif
    off  = off - (off % size);
    mask = (64'd1 << (8 * size)) - 1;
    v.e_addr = addr & 32'hFFFF_FFFC;
    v.e_be   = 4'(((1 << size) - 1) << off);
    val = longint'(wdata) & mask;
    v.e_wdata = 0;
    for (int i = 0; i < 4 / size; i++) v.e_wdata |= 32'(val << (8 * size * i));
    val = (longint'(rdata) >> (8 * off)) & mask;
    if (typ < 3'd3 && ((val >> (8 * size - 1)) & 1) == 1) val = val | ~mask;
    v.e_data = 32'(val);
    if (!legal) begin
      v.e_err = 1; v.e_we = 0; v.e_nreq = 0; v.e_lat = 1;
    end else if (ack_dly >= int'(TIMEOUT)) begin
      v.e_err = 1; v.e_we = 0; v.e_nreq = int'(TIMEOUT); v.e_lat = int'(TIMEOUT) + 1;
    end else begin
      v.e_err = 0; v.e_we = is_load; v.e_nreq = ack_dly + 1; v.e_lat = ack_dly + 2;
    end
    return v;
  endfunction

  // Issue one operation (called just after a rising edge), ack after ack_dly
  // REQ cycles, observe until completion and compare with the expectation.
  task automatic run_op(input vec_t v, input string tag);
    int          stall_cnt = 0;
    int          req_cnt = 0;
    bit          done = 0;
    bit          stable = 1;
    logic [31:0] f_addr, f_wdata, got_data;
    logic [3:0]  f_be;
    logic        f_we, got_we, got_err;
    logic [4:0]  got_rd;
    logic [4:0]  rd;
    rd = 5'($urandom_range(1, 31));
    ex_valid = 1; ex_rd = v.is_load; ex_wr = !v.is_load; ex_type = v.typ;
    ex_addr = v.addr; ex_wdata = v.wdata; ex_rd_idx = rd;
    bus_rdata = v.rdata; bus_ack = 0;
    for (int cyc = 0; cyc < 3 * int'(TIMEOUT) + 8 && !done; cyc++) begin
      bus_ack = bus_req && (req_cnt == v.ack_dly);
      @(negedge clk);
      if (stall) stall_cnt++;
      if (bus_req) begin
        if (req_cnt == 0) begin
          f_addr = bus_addr; f_be = bus_be; f_wdata = bus_wdata; f_we = bus_we;
        end else if (bus_addr !== f_addr || bus_be !== f_be ||
                     bus_wdata !== f_wdata || bus_we !== f_we) begin
          stable = 0;
        end
        req_cnt++;
      end
      if (wb_valid) begin
        done = 1; got_we = wb_we; got_err = err; got_data = wb_data; got_rd = wb_rd_idx;
      end
      @(posedge clk); #1;
    end
    ex_valid = 0; ex_rd = 0; ex_wr = 0; bus_ack = 0;
    chk({tag, " completion seen"}, 64'(done), 64'd1);
    chk({tag, " stall cycles"}, 64'(stall_cnt), 64'(v.e_lat));
    chk({tag, " bus_req cycles"}, 64'(req_cnt), 64'(v.e_nreq));
    chk({tag, " err"}, 64'(got_err), 64'(v.e_err));
    chk({tag, " wb_we"}, 64'(got_we), 64'(v.e_we));
    chk({tag, " wb_rd_idx"}, 64'(got_rd), 64'(rd));
    if (v.e_we) chk({tag, " wb_data"}, 64'(got_data), 64'(v.e_data));
    if (v.e_nreq > 0 && req_cnt > 0) begin
      chk({tag, " bus_addr"}, 64'(f_addr), 64'(v.e_addr));
      chk({tag, " bus_be"}, 64'(f_be), 64'(v.e_be));
      chk({tag, " bus_we"}, 64'(f_we), 64'(!v.is_load));
      if (!v.is_load) chk({tag, " bus_wdata"}, 64'(f_wdata), 64'(v.e_wdata));
      chk({tag, " bus fields stable"}, 64'(stable), 64'd1);
    end
    @(negedge clk);
    chk({tag, " wb_valid single pulse"}, 64'(wb_valid), 64'd0);
    chk({tag, " err single pulse"}, 64'(err), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t        tbl[12];
    vec_t        v;
    logic [2:0]  t;
    logic        ld;
    int          pick;

    // Reset with a load presented: everything must read zero, stall included.
    rst = 0; ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_type = LSU_W;
    ex_addr = 32'h104; ex_wdata = 0; ex_rd_idx = 5'd3; bus_ack = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset bus_req", 64'(bus_req), 64'd0);
    chk("reset bus_be", 64'(bus_be), 64'd0);
    chk("reset bus_addr", 64'(bus_addr), 64'd0);
    chk("reset wb_valid", 64'(wb_valid), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset wb_data", 64'(wb_data), 64'd0);
    @(posedge clk); #1;
    rst = 1; ex_valid = 0; ex_rd = 0;
    @(posedge clk); #1;

    //            typ     ld addr          wdata         rdata         dly  e_addr        e_be  e_wdata       e_data        err we nreq lat
    tbl[0]  = mk(LSU_W,   1, 32'h104,      32'h0,        32'h8000_00F0, 1,  32'h104,      4'hF, 32'h0,        32'h8000_00F0, 0, 1, 2, 3);
    tbl[1]  = mk(LSU_B,   1, 32'h203,      32'h0,        32'h8100_0000, 0,  32'h200,      4'h8, 32'h0,        32'hFFFF_FF81, 0, 1, 1, 2);
    tbl[2]  = mk(LSU_BU,  1, 32'h203,      32'h0,        32'h8100_0000, 0,  32'h200,      4'h8, 32'h0,        32'h0000_0081, 0, 1, 1, 2);
    tbl[3]  = mk(LSU_H,   0, 32'h302,      32'h1234_ABCD, 32'h0,        1,  32'h300,      4'hC, 32'hABCD_ABCD, 32'h0,        0, 0, 2, 3);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[4]  = mk(LSU_W,   1, 32'h101,      32'h0,        32'hCAFE_F00D, 0,  32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 0, 1);
`else
    tbl[4]  = mk(LSU_W,   1, 32'h101,      32'h0,        32'hCAFE_F00D, 0,  32'h100,      4'hF, 32'h0,        32'hCAFE_F00D, 0, 1, 1, 2);
`endif
    tbl[5]  = mk(LSU_BAD, 1, 32'h400,      32'h0,        32'h1234_5678, 0,  32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 0, 1);
    tbl[6]  = mk(LSU_D,   1, 32'h408,      32'h0,        32'h1234_5678, 0,  32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 0, 1);
    tbl[7]  = mk(LSU_H,   1, 32'h206,      32'h0,        32'h8001_0000, 0,  32'h204,      4'hC, 32'h0,        32'hFFFF_8001, 0, 1, 1, 2);
    tbl[8]  = mk(LSU_B,   0, 32'h401,      32'h0000_005A, 32'h0,        0,  32'h400,      4'h2, 32'h5A5A_5A5A, 32'h0,        0, 0, 1, 2);
    tbl[9]  = mk(LSU_W,   1, 32'h500,      32'h0,        32'h0,        100, 32'h500,      4'hF, 32'h0,        32'h0,        1, 0, 4, 5);
    tbl[10] = mk(LSU_HU,  1, 32'h20A,      32'h0,        32'h9ABC_0000, 2,  32'h208,      4'hC, 32'h0,        32'h0000_9ABC, 0, 1, 3, 4);
    tbl[11] = mk(LSU_W,   0, 32'h10C,      32'hDEAD_BEEF, 32'h0,        3,  32'h10C,      4'hF, 32'hDEAD_BEEF, 32'h0,        0, 0, 4, 5);

    for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Non-memory instruction passes straight through.
    ex_valid = 1; ex_rd = 0; ex_wr = 0; ex_type = LSU_W;
    repeat (3) begin
      @(negedge clk);
      chk("nonmem stall", 64'(stall), 64'd0);
      chk("nonmem wb_valid", 64'(wb_valid), 64'd0);
      chk("nonmem bus_req", 64'(bus_req), 64'd0);
      @(posedge clk); #1;
    end
    ex_valid = 0;

    // Stray ack while idle is ignored.
    bus_ack = 1; bus_rdata = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge clk);
      chk("idle ack wb_valid", 64'(wb_valid), 64'd0);
      chk("idle ack bus_req", 64'(bus_req), 64'd0);
      @(posedge clk); #1;
    end
    bus_ack = 0;

    // Reset in the middle of a request, then a late ack.
    ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_type = LSU_W; ex_addr = 32'h600; ex_rd_idx = 5'd9;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid in req", 64'(bus_req), 64'd1);
    @(posedge clk); #1;
    rst = 0; ex_valid = 0; ex_rd = 0;
    @(negedge clk);
    chk("rstmid stall during reset", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rstmid bus_req", 64'(bus_req), 64'd0);
    chk("rstmid bus_we", 64'(bus_we), 64'd0);
    chk("rstmid bus_be", 64'(bus_be), 64'd0);
    chk("rstmid bus_addr", 64'(bus_addr), 64'd0);
    chk("rstmid bus_wdata", 64'(bus_wdata), 64'd0);
    chk("rstmid wb_valid", 64'(wb_valid), 64'd0);
    chk("rstmid wb_we", 64'(wb_we), 64'd0);
    chk("rstmid wb_data", 64'(wb_data), 64'd0);
    chk("rstmid wb_rd_idx", 64'(wb_rd_idx), 64'd0);
    chk("rstmid err", 64'(err), 64'd0);
    chk("rstmid stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'h1357_9BDF;
    repeat (3) begin
      @(negedge clk);
      chk("late ack wb_valid", 64'(wb_valid), 64'd0);
      chk("late ack bus_req", 64'(bus_req), 64'd0);
      @(posedge clk); #1;
      bus_ack = 0;
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      ld   = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      t = 3'($urandom_range(0, 7));
      else if (ld)        t = 3'($urandom_range(0, 5) == 3 ? 2 : $urandom_range(0, 5));
      else                t = 3'($urandom_range(0, 2));
      v = model(t, ld, $urandom, $urandom, $urandom, int'($urandom_range(0, TIMEOUT + 1)));
      run_op(v, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
